obi_data_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the core-side OBI-style data bus (req/gnt/rvalid).
- Shares the single mm_ram data port between the core LSU (master 0) and an auxiliary requester (master 1), e.g. a testbench preloader or DMA.
- Tracks the owner of every outstanding transaction so read/write responses return to the correct master.
- Sits between the core data port and mm_ram in the core testbench wrapper.

---
 rtl/obi_data_arbiter.sv | 179 +++++++++++++++++
 tb/tb_obi_data_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/obi_data_arbiter.sv
// obi_fifo: small generic synchronous FIFO, registered count/flags, wrap-modulo-DEPTH pointers.
// Latency: pushed entry visible at head the next cycle. Backpressure: push ignored when full, pop ignored when empty.
module obi_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_vld,
  input  logic [WIDTH-1:0]               push_dat,
  input  logic                           pop_rdy,
  output logic [WIDTH-1:0]               pop_dat,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push_vld & ~full;
  assign pop_ok  = pop_rdy & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wrap_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= wrap_inc(rd_ptr);
      if (push_ok && !pop_ok)      cnt <= cnt + CNT_W'(1);
      else if (pop_ok && !push_ok) cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// obi_data_arbiter: two-master round-robin arbiter onto one OBI data slave, routing in-order responses by owner.
// Latency: zero-cycle request path. Backpressure: holds the selection locked until s_gnt_i; stops requesting when the owner FIFO is full.
module obi_data_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   m0_req_i,
  input  logic [ADDR_WIDTH-1:0]                  m0_addr_i,
  input  logic                                   m0_we_i,
  input  logic [DATA_WIDTH/8-1:0]                m0_be_i,
  input  logic [DATA_WIDTH-1:0]                  m0_wdata_i,
  output logic                                   m0_gnt_o,
  output logic                                   m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  m0_rdata_o,
  input  logic                                   m1_req_i,
  input  logic [ADDR_WIDTH-1:0]                  m1_addr_i,
  input  logic                                   m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]                m1_be_i,
  input  logic [DATA_WIDTH-1:0]                  m1_wdata_i,
  output logic                                   m1_gnt_o,
  output logic                                   m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  m1_rdata_o,
  output logic                                   s_req_o,
  output logic [ADDR_WIDTH-1:0]                  s_addr_o,
  output logic                                   s_we_o,
  output logic [DATA_WIDTH/8-1:0]                s_be_o,
  output logic [DATA_WIDTH-1:0]                  s_wdata_o,
  input  logic                                   s_gnt_i,
  input  logic                                   s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   protocol_err_o
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
  } obi_req_t;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  lock_state_e state_q, state_d;
  logic        lock_id_q, lock_id_d;
  logic        rr_ptr_q;
  logic        sel, sel_req, hs;
  logic        fifo_full, fifo_empty, head_owner;
  logic        err_q;
  obi_req_t    m0_req_dat, m1_req_dat, s_req_dat;

  assign m0_req_dat = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
  assign m1_req_dat = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

  // A stalled request stays pinned to its master: OBI forbids retracting req before gnt.
  always_comb begin
    if (state_q == LOCKED)       sel = lock_id_q;
    else if (m0_req_i != m1_req_i) sel = m1_req_i;
    else                         sel = rr_ptr_q;
  end

  assign s_req_dat = sel ? m1_req_dat : m0_req_dat;
  assign sel_req   = sel ? m1_req_i : m0_req_i;
  // fifo_full is registered, so a same-cycle pop does not reopen the request path.
  assign s_req_o   = sel_req & ~fifo_full & rst_ni;
  assign hs        = s_req_o & s_gnt_i;

  assign s_addr_o  = s_req_dat.addr;
  assign s_we_o    = s_req_dat.we;
  assign s_be_o    = s_req_dat.be;
  assign s_wdata_o = s_req_dat.wdata;

  assign m0_gnt_o  = hs & ~sel;
  assign m1_gnt_o  = hs & sel;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      UNLOCKED: if (s_req_o && !s_gnt_i) begin
        state_d   = LOCKED;
        lock_id_d = sel;
      end
      LOCKED:   if (hs) state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= UNLOCKED;
      lock_id_q <= 1'b0;
      rr_ptr_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      if (hs) rr_ptr_q <= ~sel;
      if (s_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  obi_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (hs),
    .push_dat (sel),
    .pop_rdy  (s_rvalid_i),
    .pop_dat  (head_owner),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding_o)
  );

  assign m0_rvalid_o    = s_rvalid_i & ~fifo_empty & ~head_owner;
  assign m1_rvalid_o    = s_rvalid_i & ~fifo_empty & head_owner;
  assign m0_rdata_o     = s_rdata_i;
  assign m1_rdata_o     = s_rdata_i;
  assign protocol_err_o = err_q;
endmodule

// File: tb/tb_obi_data_arbiter.sv
// Scoreboard bench for obi_data_arbiter: expected responses queued when grants are driven, popped on m*_rvalid_o.
`timescale 1ns/1ps
module tb_obi_data_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;
  logic [1:0]  outstanding_o;
  logic        protocol_err_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  obi_data_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                       input logic gnt, input logic rv, input logic [31:0] rd);
    m0_req_i = r0; m0_addr_i = a0;
    m1_req_i = r1; m1_addr_i = a1;
    s_gnt_i = gnt; s_rvalid_i = rv; s_rdata_i = rd;
  endtask

  // Drive one cycle just after the rising edge, then move to the falling edge for sampling.
  task automatic cyc(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                     input logic gnt, input logic rv, input logic [31:0] rd);
    @(posedge clk_i);
    #1;
    drive(r0, a0, r1, a1, gnt, rv, rd);
    @(negedge clk_i);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  always @(negedge clk_i) begin : rsp_mon
    exp_t e;
    if (rst_ni && (m0_rvalid_o || m1_rvalid_o)) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_owner", {30'h0, m1_rvalid_o, m0_rvalid_o}, e.owner ? 32'h2 : 32'h1);
        check_eq("rsp_data", e.owner ? m1_rdata_o : m0_rdata_o, e.data);
      end
    end
  end

  initial begin
    m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = 32'h0000_AAAA;
    m1_we_i = 1'b1; m1_be_i = 4'h3; m1_wdata_i = 32'h1111_2222;
    drive(1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 1'b1, 32'h0);

    // Outputs held low while in reset, even with live inputs.
    @(negedge clk_i);
    check_eq("rst_s_req", {31'h0, s_req_o}, 32'h0);
    check_eq("rst_gnt", {30'h0, m1_gnt_o, m0_gnt_o}, 32'h0);
    check_eq("rst_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
    check_eq("rst_outstanding", {30'h0, outstanding_o}, 32'h0);
    check_eq("rst_perr", {31'h0, protocol_err_o}, 32'h0);
    @(posedge clk_i);
    #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b1;

    // Single master read.
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("t1_s_req", {31'h0, s_req_o}, 32'h1);
    check_eq("t1_m0_gnt", {31'h0, m0_gnt_o}, 32'h1);
    check_eq("t1_m1_gnt", {31'h0, m1_gnt_o}, 32'h0);
    check_eq("t1_s_addr", s_addr_o, 32'h100);
    exp_q.push_back('{owner: 1'b0, data: 32'hDEAD_BEEF});
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check_eq("t1_outstanding", {30'h0, outstanding_o}, 32'h1);
    check_eq("t1_m0_rvalid", {31'h0, m0_rvalid_o}, 32'h1);
    idle();
    check_eq("t1_outstanding_done", {30'h0, outstanding_o}, 32'h0);

    // Fresh reset so round robin starts at m0; then contention with pipelined responses.
    @(posedge clk_i); #1; rst_ni = 1'b0;
    @(posedge clk_i); #1; rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic own;
      own = logic'(i % 2);
      cyc(1'b1, 32'h200, 1'b1, 32'h300, 1'b1, i > 0, 32'hA000_0000 + 32'(i) - 32'h1);
      check_eq("t2_m0_gnt", {31'h0, m0_gnt_o}, {31'h0, ~own});
      check_eq("t2_m1_gnt", {31'h0, m1_gnt_o}, {31'h0, own});
      check_eq("t2_s_addr", s_addr_o, own ? 32'h300 : 32'h200);
      if (i > 0) check_eq("t2_outstanding", {30'h0, outstanding_o}, 32'h1);
      exp_q.push_back('{owner: own, data: 32'hA000_0000 + 32'(i)});
    end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0003);
    idle();

    // Lock on stall: m1 holds the bus until granted even after m0 joins.
    cyc(1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
    check_eq("t3_s_req", {31'h0, s_req_o}, 32'h1);
    check_eq("t3_c1_addr", s_addr_o, 32'h400);
    check_eq("t3_c1_m1_gnt", {31'h0, m1_gnt_o}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 32'h500, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
      check_eq("t3_locked_addr", s_addr_o, 32'h400);
      check_eq("t3_locked_m0_gnt", {31'h0, m0_gnt_o}, 32'h0);
    end
    cyc(1'b1, 32'h500, 1'b1, 32'h400, 1'b1, 1'b0, 32'h0);
    check_eq("t3_c4_m1_gnt", {31'h0, m1_gnt_o}, 32'h1);
    check_eq("t3_c4_m0_gnt", {31'h0, m0_gnt_o}, 32'h0);
    check_eq("t3_c4_addr", s_addr_o, 32'h400);
    check_eq("t3_c4_we", {31'h0, s_we_o}, 32'h1);
    check_eq("t3_c4_wdata", s_wdata_o, 32'h1111_2222);
    check_eq("t3_c4_be", {28'h0, s_be_o}, 32'h3);
    exp_q.push_back('{owner: 1'b1, data: 32'h0000_00B1});
    cyc(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_00B1);
    check_eq("t3_c5_m0_gnt", {31'h0, m0_gnt_o}, 32'h1);
    check_eq("t3_c5_addr", s_addr_o, 32'h500);
    exp_q.push_back('{owner: 1'b0, data: 32'h0000_00B2});
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00B2);
    idle();

    // Outstanding limit: two grants with responses held off.
    cyc(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("t4_d1_m0_gnt", {31'h0, m0_gnt_o}, 32'h1);
    exp_q.push_back('{owner: 1'b0, data: 32'h0000_00C1});
    cyc(1'b0, 32'h0, 1'b1, 32'h700, 1'b1, 1'b0, 32'h0);
    check_eq("t4_d2_m1_gnt", {31'h0, m1_gnt_o}, 32'h1);
    exp_q.push_back('{owner: 1'b1, data: 32'h0000_00C2});
    cyc(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("t4_full_outstanding", {30'h0, outstanding_o}, 32'h2);
    check_eq("t4_full_s_req", {31'h0, s_req_o}, 32'h0);
    check_eq("t4_full_m0_gnt", {31'h0, m0_gnt_o}, 32'h0);
    cyc(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_00C1);
    check_eq("t4_pop_s_req", {31'h0, s_req_o}, 32'h0);
    check_eq("t4_pop_m0_gnt", {31'h0, m0_gnt_o}, 32'h0);
    cyc(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("t4_after_outstanding", {30'h0, outstanding_o}, 32'h1);
    check_eq("t4_after_s_req", {31'h0, s_req_o}, 32'h1);
    check_eq("t4_after_m0_gnt", {31'h0, m0_gnt_o}, 32'h1);
    exp_q.push_back('{owner: 1'b0, data: 32'h0000_00C3});
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00C2);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00C3);
    idle();
    check_eq("t4_drained", {30'h0, outstanding_o}, 32'h0);

    // Response with nothing outstanding is dropped and flagged.
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0BAD);
    check_eq("t5_drop_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
    check_eq("t5_perr_before", {31'h0, protocol_err_o}, 32'h0);
    idle();
    check_eq("t5_perr_set", {31'h0, protocol_err_o}, 32'h1);
    idle();
    idle();
    check_eq("t5_perr_sticky", {31'h0, protocol_err_o}, 32'h1);

    // Asynchronous reset in the middle of a burst.
    cyc(1'b1, 32'h800, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 32'h800, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("t6_pre_outstanding", {30'h0, outstanding_o}, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("t6_async_outstanding", {30'h0, outstanding_o}, 32'h0);
    check_eq("t6_async_perr", {31'h0, protocol_err_o}, 32'h0);
    check_eq("t6_async_s_req", {31'h0, s_req_o}, 32'h0);
    exp_q.delete();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk_i); #1; rst_ni = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_5757);
    check_eq("t6_stale_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
    idle();
    check_eq("t6_stale_perr", {31'h0, protocol_err_o}, 32'h1);

    check_eq("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
